mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single memory port of the multi-cycle datapath between the instruction-fetch requester and the load/store (data) requester. It serializes one transaction at a time against a fixed-latency memory, gives data accesses priority, and guarantees fetch progress through an anti-starvation counter. Both requesters stall on their request line until the arbiter pulses their ready.

## Interface
- ADDR_W, 32, address width of both requesters and memory
- DATA_W, 32, data width
- MEM_LAT, 2, memory read/write latency in cycles; legal range 1..15
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  registered fetch data; holds until next fetch completes
- d_req  in  1  data request; held high until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  registered load data; unchanged by stores
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en rises
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, BUSY, RESP. Reset value: IDLE; every output 0; starve counter 0; owner = fetch.
- IDLE: if neither request, stay. Otherwise choose a winner and latch owner, address, we (d_we for data, 0 for fetch) and wdata into registers. Then go to BUSY with a latency counter of MEM_LAT-1.
- Winner rule:
  - if_req alone: fetch.
  - d_req alone: data.
  - Both: data, unless starve counter == STARVE_MAX, in which case fetch.
- Starve counter:
  - +1 on each data grant while if_req is high.
  - Cleared on fetch grant.
  - Cleared in any cycle if_req is low.
  - Saturates at STARVE_MAX.
- BUSY: mem_en = 1 and mem_addr/mem_we/mem_wdata driven from the latched registers for all MEM_LAT cycles, stable throughout. Counter decrements each cycle. At the edge where the counter is 0, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
- RESP: owner's ready = 1 for exactly one cycle; mem_en = 0. Always returns to IDLE, never arbitrates in RESP, so the requester's req drop at the ready edge is never re-serviced.
- Request inputs are sampled only in IDLE. Address/data changes during BUSY are ignored.
- Reset asserted mid-transaction: abandon immediately, outputs 0, no ready pulse. The requester must re-request.

## Timing
- Request sampled at edge E0 → BUSY from E0 for MEM_LAT cycles → RESP (ready high) in cycle E0+MEM_LAT → IDLE at E0+MEM_LAT+1.
- Latency, req-high cycle to ready: MEM_LAT+1 cycles.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- mem_en is high exactly MEM_LAT consecutive cycles per transaction.
- if_ready and d_ready are never high together.
- busy = (state != IDLE). busy is 0 during reset.

## Test plan
- Reset: hold reset=0 with if_req=d_req=1 → all outputs 0, busy 0, mem_en 0. Release → fetch-or-data grant on the first edge.
- Lone fetch, MEM_LAT=2: if_addr=0x00400000, memory returns 0x8C080004 → mem_en high 2 cycles with mem_addr=0x00400000, if_ready pulses 1 cycle 3 cycles after the request, if_rdata=0x8C080004.
- Store then load: d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF → mem_we=1 for 2 cycles, d_ready pulse, d_rdata unchanged. Then load of the same address → d_rdata=0xDEADBEEF.
- Contention, STARVE_MAX=4, both reqs held high, data re-requesting immediately → grants D,D,D,D,F,D,D,D,D,F; no simultaneous ready pulses.
- Reset mid-BUSY: assert reset in the second BUSY cycle of a fetch → mem_en drops asynchronously, no if_ready pulse. After release with if_req still high → fresh full MEM_LAT+1 transaction.
- Input change during BUSY: change d_addr to 0x20 mid-transaction → mem_addr keeps the originally latched value until RESP.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two memory requesters, the memory and the arbiter.
// slave: arbiter side (requests and mem_rdata in; ready, rdata, mem_* and busy out).
// master: environment side (the requesters and the memory), with the directions reversed.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Ports: clk, reset (async, active-low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);
    localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        lat_cnt;
    logic [3:0]        starve;
    logic              owner_d;
    logic              grant;
    logic              grant_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              en;

    // Data wins a collision unless fetch has already lost STARVE_MAX times.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    grant    = 1'b1;
                    grant_d  = bus.d_req && !(bus.if_req && starve == SMAX);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve     <= '0;
            owner_d    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_nx;

            // Counts data grants that passed over a waiting fetch.
            if (!bus.if_req) begin
                starve <= '0;
            end else if (grant && !grant_d) begin
                starve <= '0;
            end else if (grant && starve != SMAX) begin
                starve <= starve + 4'd1;
            end

            if (grant) begin
                owner_d <= grant_d;
                addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                we_q    <= grant_d && bus.d_we;
                wdata_q <= grant_d ? bus.d_wdata : '0;
                lat_cnt <= LAT_INIT;
            end else if (state == BUSY && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            // Last BUSY cycle: read data is valid now; stores leave rdata alone.
            if (state == BUSY && lat_cnt == '0 && !we_q) begin
                if (owner_d) begin
                    d_rdata_q <= bus.mem_rdata;
                end else begin
                    if_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign en            = (state == BUSY);
    assign bus.mem_en    = en;
    assign bus.mem_we    = en && we_q;
    assign bus.mem_addr  = en ? addr_q : '0;
    assign bus.mem_wdata = en ? wdata_q : '0;
    assign bus.if_ready  = (state == RESP) && !owner_d;
    assign bus.d_ready   = (state == RESP) && owner_d;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);
endmodule
